timebase_gen: RTL and testbench

TIMEBASE_GEN -- requirements
Module: timebase_gen

---
 rtl/timebase_pkg.sv | 19 +
 rtl/timebase_tick_channel.sv | 79 +++++++
 rtl/timebase_gen.sv | 80 ++++++++
 tb/tb_timebase_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// Shared types and constants for the timebase generator and its tick channels.
package timebase_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int DEF_DIV_W = 30;

  // Channel index width, never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timebase_tick_channel.sv
// One programmable tick channel: IDLE/RUN state, wrap counter, stored divisor and mode.
module tick_channel
  import timebase_pkg::*;
#(
  parameter int               DIV_W   = DEF_DIV_W,
  // Non-zero makes the channel leave reset already running with this divisor.
  parameter logic [DIV_W-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic             tick,
  output logic             active
);

  ch_state_t        state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic             mode, mode_nxt;
  logic             tick_nxt;
  logic             term;

  assign term = (cnt == (div - DIV_W'(1)));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = div;
    mode_nxt  = mode;
    tick_nxt  = 1'b0;
    // A write overrides any terminal count on the same edge.
    if (wr) begin
      cnt_nxt = '0;
      if (wr_div != '0) begin
        div_nxt   = wr_div;
        mode_nxt  = wr_mode;
        state_nxt = CH_RUN;
      end else begin
        state_nxt = CH_IDLE;
      end
    end else if ((state == CH_RUN) && en) begin
      if (term) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        if (mode == MODE_ONESHOT) begin
          state_nxt = CH_IDLE;
        end
      end else begin
        cnt_nxt = cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (RST_DIV != '0) begin
        state <= CH_RUN;
      end else begin
        state <= CH_IDLE;
      end
      cnt  <= '0;
      div  <= RST_DIV;
      mode <= MODE_PERIODIC;
      tick <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      div   <= div_nxt;
      mode  <= mode_nxt;
      tick  <= tick_nxt;
    end
  end

  assign active = (state == CH_RUN);

endmodule

// File: rtl/timebase_gen.sv
// Programmable multi-channel tick generator with a fixed once-per-CLK_HZ sec_tick.
module timebase_gen
  import timebase_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DEF_DIV_W,
  localparam int CH_W  = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active,
  output logic              sec_tick
);

  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_chk_num_ch
    $error("timebase_gen: NUM_CH must be in 1..16");
  end
  if ((DIV_W < 2) || (DIV_W > 62)) begin : g_chk_div_w
    $error("timebase_gen: DIV_W must be in 2..62");
  end
  if ((CLK_HZ < 1) || (longint'(CLK_HZ) > ((longint'(1) << DIV_W) - longint'(1)))) begin : g_chk_clk_hz
    $error("timebase_gen: CLK_HZ does not fit in DIV_W bits");
  end

  logic              accept;
  logic [NUM_CH-1:0] wr_sel;
  logic              sec_active_unused;

  assign accept = cfg_valid && cfg_ready;

  // Ready drops for exactly one cycle after each accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= !accept;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign wr_sel[gi] = accept && (cfg_ch == CH_W'(gi));

    tick_channel #(
      .DIV_W   (DIV_W),
      .RST_DIV ('0)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .wr      (wr_sel[gi]),
      .wr_div  (cfg_div),
      .wr_mode (cfg_oneshot),
      .tick    (tick[gi]),
      .active  (active[gi])
    );
  end

  tick_channel #(
    .DIV_W   (DIV_W),
    .RST_DIV (DIV_W'(CLK_HZ))
  ) u_sec (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wr      (1'b0),
    .wr_div  ('0),
    .wr_mode (MODE_PERIODIC),
    .tick    (sec_tick),
    .active  (sec_active_unused)
  );

endmodule

// File: tb/tb_timebase_gen.sv
// Directed bench for timebase_gen with a tick scoreboard and an enabled-edge sec_tick model.
module tb_timebase_gen;

  localparam int CLK_HZ = 10;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_oneshot;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] active;
  logic             sec_tick;

  timebase_gen #(
    .CLK_HZ (CLK_HZ),
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_oneshot (cfg_oneshot),
    .tick        (tick),
    .active      (active),
    .sec_tick    (sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int ch;
  } ev_t;

  ev_t         q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  bit          exp_ready = 1'b0;
  logic [3:0]  exp_active = '0;
  int          act_off[NUM_CH];
  int          t;
  int          t2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_tick(input int at, input int ch);
    ev_t e;
    e.cyc = at;
    e.ch  = ch;
    q.push_back(e);
  endtask

  // Advance one edge, update the expected state, then check all outputs.
  task automatic cycle();
    logic [3:0] exp_tick;
    bit         acc;
    bit         sec_exp;
    ev_t        keep[$];
    @(posedge clk);
    cyc++;
    acc = cfg_valid && exp_ready && !rst;
    if (rst) begin
      en_cnt     = 0;
      exp_ready  = 1'b0;
      exp_active = '0;
      q.delete();
      for (int c = 0; c < NUM_CH; c++) act_off[c] = -1;
    end else begin
      if (en) en_cnt++;
      exp_ready = !(cfg_valid && exp_ready);
    end
    sec_exp = !rst && en && (en_cnt > 0) && ((en_cnt % CLK_HZ) == 0);
    if (acc) begin
      exp_active[cfg_ch] = (cfg_div != '0);
      act_off[cfg_ch]    = (cfg_oneshot && (cfg_div != '0)) ? cyc + int'(cfg_div) : -1;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (act_off[c] == cyc) begin
        exp_active[c] = 1'b0;
        act_off[c]    = -1;
      end
    end
    exp_tick = '0;
    foreach (q[i]) begin
      if (q[i].cyc == cyc) exp_tick[q[i].ch] = 1'b1;
      else keep.push_back(q[i]);
    end
    q = keep;
    #1;
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("active", 32'(active), 32'(exp_active));
    chk("sec_tick", 32'(sec_tick), 32'(sec_exp));
    chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
  endtask

  task automatic wr(input int ch, input int div, input bit os);
    cfg_valid   = 1'b1;
    cfg_ch      = 2'(ch);
    cfg_div     = DIV_W'(div);
    cfg_oneshot = os;
    cycle();
    cfg_valid   = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) act_off[c] = -1;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;

    // Reset state.
    repeat (3) cycle();

    // Free run: sec_tick at enabled edges 10, 20, 30, no channel activity.
    rst = 1'b0; en = 1'b1;
    repeat (35) cycle();

    // Channel 1 periodic div=5, then stopped with div=0.
    wr(1, 5, 1'b0);
    t = cyc;
    push_tick(t + 5, 1); push_tick(t + 10, 1); push_tick(t + 15, 1);
    while (cyc < t + 16) cycle();
    wr(1, 0, 1'b0);
    chk("ch1_stopped", 32'(active[1]), 32'd0);
    repeat (8) cycle();

    // Channel 2 one-shot div=3; a back-to-back second write must be refused.
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = DIV_W'(3); cfg_oneshot = 1'b1;
    cycle();
    t = cyc;
    cfg_ch = 2'd3; cfg_div = DIV_W'(2); cfg_oneshot = 1'b0;
    cycle();
    cfg_valid = 1'b0;
    push_tick(t + 3, 2);
    while (cyc < t + 3) cycle();
    chk("ch2_oneshot_fall", 32'(active[2]), 32'd0);
    repeat (10) cycle();

    // Channel 0 div=4 with a 3-cycle enable drop mid-period.
    wr(0, 4, 1'b0);
    t = cyc;
    push_tick(t + 4, 0); push_tick(t + 11, 0); push_tick(t + 15, 0); push_tick(t + 19, 0);
    while (cyc < t + 5) cycle();
    en = 1'b0;
    repeat (3) cycle();
    en = 1'b1;
    // Rewrite on the terminal-count edge t+23: that tick is suppressed.
    while (cyc < t + 22) cycle();
    wr(0, 6, 1'b0);
    t2 = cyc;
    push_tick(t2 + 6, 0); push_tick(t2 + 12, 0);
    while (cyc < t2 + 13) cycle();
    wr(0, 0, 1'b0);
    repeat (12) cycle();

    // Several channels running, reset mid-period discards everything.
    wr(0, 7, 1'b0);
    cycle();
    wr(1, 9, 1'b0);
    cycle();
    wr(3, 8, 1'b0);
    cycle();
    chk("all_running", 32'(active), 32'hb);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (25) cycle();

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
